// File: rtl/zbt_audio_pkg.sv
// Shared state encodings and sizing for the ZBT song transport sequencer.
package zbt_audio_pkg;

  localparam int unsigned ADDR_W_DFLT    = 19;
  localparam int unsigned SLOT_BITS_DFLT = 3;
  localparam int unsigned SLOT_W         = ADDR_W_DFLT - SLOT_BITS_DFLT;
  localparam int unsigned SAMP_PER_W     = 3;
  localparam int unsigned NUM_SONGS      = 16;
  localparam int unsigned SONG_W         = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPlay   = 3'd1,
    StRec    = 3'd2,
    StPaused = 3'd3,
    StDone   = 3'd4
  } state_e;

endpackage

// File: rtl/song_length_table.sv
// Recorded length (in words) of each song slot; async read, cleared by reset.
module song_length_table
  import zbt_audio_pkg::*;
#(
  parameter int unsigned WIDTH = SLOT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [SONG_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [SONG_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_len [NUM_SONGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_SONGS; i++) begin
        r_len[i] <= '0;
      end
    end else if (i_we) begin
      r_len[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_len[i_raddr];

endmodule

// File: rtl/zbt_song_transport_ctrl.sv
// Transport sequencer: maps start/stop/pause/record controls onto memory-processor
// control strobes and walks the per-slot ZBT word address on the selected bank.
module zbt_song_transport_ctrl
  import zbt_audio_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DFLT,
  parameter int unsigned SLOT_BITS = SLOT_BITS_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ready,
  input  logic              i_btn_start,
  input  logic              i_btn_stop,
  input  logic              i_btn_pause,
  input  logic              i_record_sw,
  input  logic [SONG_W-1:0] i_song_sel,
  output logic              o_start_song,
  output logic              o_record_mode,
  output logic [SONG_W-1:0] o_song_choice,
  output logic              o_pause_song,
  output logic              o_song_done,
  output logic [ADDR_W-1:0] o_addr0,
  output logic [ADDR_W-1:0] o_addr1,
  output logic [2:0]        o_state
);

  localparam int unsigned SW        = ADDR_W - SLOT_BITS;
  localparam logic [1:0]  SAMP_LAST = 2'(SAMP_PER_W - 1);

  state_e r_state, w_state_nxt;
  state_e r_origin, w_origin_nxt;

  logic              r_start_song, w_start_nxt;
  logic              r_record_mode, w_rec_nxt;
  logic [SONG_W-1:0] r_song_choice, w_choice_nxt;
  logic [1:0]        r_samp_cnt, w_samp_nxt;
  logic [SW-1:0]     r_word_idx, w_word_nxt;
  logic [ADDR_W-1:0] r_addr0, r_addr1, w_addr0_nxt, w_addr1_nxt, w_addr;

  logic              w_active, w_ev_stop, w_ev_start, w_count, w_wrap;
  logic              w_play_end, w_rec_full, w_at_end, w_finish;
  logic [SONG_W-1:0] w_len_raddr;
  logic              w_len_we;
  logic [SW-1:0]     w_len;

  song_length_table #(
    .WIDTH (SW)
  ) u_len_tbl (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_len_we),
    .i_waddr (r_song_choice),
    .i_wdata (r_word_idx),
    .i_raddr (w_len_raddr),
    .o_rdata (w_len)
  );

  // Event decode: stop beats start beats pause; a control event swallows a coincident sample.
  always_comb begin
    w_active    = (r_state == StPlay) || (r_state == StRec) || (r_state == StPaused);
    w_ev_stop   = i_btn_stop && w_active;
    w_ev_start  = i_btn_start && !w_ev_stop;
    w_count     = i_ready && !w_ev_stop && !w_ev_start &&
                  ((r_state == StPlay) || (r_state == StRec));
    w_wrap      = w_count && (r_samp_cnt == SAMP_LAST);
    w_len_raddr = w_ev_start ? i_song_sel : r_song_choice;
    w_play_end  = (r_word_idx + SW'(1)) == w_len;
    w_rec_full  = r_word_idx == {SW{1'b1}};
    w_at_end    = (r_state == StPlay) ? w_play_end : w_rec_full;
    w_finish    = w_wrap && w_at_end;
    w_len_we    = (w_ev_stop && ((r_state == StRec) ||
                                 ((r_state == StPaused) && (r_origin == StRec)))) ||
                  (w_finish && (r_state == StRec));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_origin <= StPlay;
    end else begin
      r_state  <= w_state_nxt;
      r_origin <= w_origin_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_origin_nxt = r_origin;
    if (w_ev_stop) begin
      w_state_nxt = StDone;
    end else if (w_ev_start) begin
      if (i_record_sw) begin
        w_state_nxt = StRec;
      end else begin
        w_state_nxt = (w_len == '0) ? StDone : StPlay;
      end
    end else begin
      if (i_btn_pause) begin
        case (r_state)
          StPlay, StRec: begin
            w_state_nxt  = StPaused;
            w_origin_nxt = r_state;
          end
          StPaused: w_state_nxt = r_origin;
          default: ;
        endcase
      end
      if (w_finish) begin
        w_state_nxt = StDone;
      end
    end
  end

  always_comb begin
    o_pause_song = (r_state == StPaused) || (r_state == StIdle);
    o_song_done  = (r_state == StDone) || (r_state == StIdle);
    o_state      = r_state;
  end

  // Datapath next values; the address is formed from the next slot/word so it lands
  // one cycle after the ready that wraps the sample counter.
  always_comb begin
    w_start_nxt  = w_ev_start;
    w_rec_nxt    = r_record_mode;
    w_choice_nxt = r_song_choice;
    w_samp_nxt   = r_samp_cnt;
    w_word_nxt   = r_word_idx;
    if (w_ev_start) begin
      w_rec_nxt    = i_record_sw;
      w_choice_nxt = i_song_sel;
      w_samp_nxt   = '0;
      w_word_nxt   = '0;
    end else if (w_count) begin
      w_samp_nxt = w_wrap ? 2'd0 : r_samp_cnt + 2'd1;
      if (w_wrap && !w_at_end) begin
        w_word_nxt = r_word_idx + SW'(1);
      end
    end
    w_addr      = {w_choice_nxt[SLOT_BITS-1:0], w_word_nxt};
    w_addr0_nxt = w_choice_nxt[SONG_W-1] ? '0 : w_addr;
    w_addr1_nxt = w_choice_nxt[SONG_W-1] ? w_addr : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_song  <= 1'b0;
      r_record_mode <= 1'b0;
      r_song_choice <= '0;
      r_samp_cnt    <= '0;
      r_word_idx    <= '0;
      r_addr0       <= '0;
      r_addr1       <= '0;
    end else begin
      r_start_song  <= w_start_nxt;
      r_record_mode <= w_rec_nxt;
      r_song_choice <= w_choice_nxt;
      r_samp_cnt    <= w_samp_nxt;
      r_word_idx    <= w_word_nxt;
      r_addr0       <= w_addr0_nxt;
      r_addr1       <= w_addr1_nxt;
    end
  end

  assign o_start_song  = r_start_song;
  assign o_record_mode = r_record_mode;
  assign o_song_choice = r_song_choice;
  assign o_addr0       = r_addr0;
  assign o_addr1       = r_addr1;

endmodule

// File: tb/tb_zbt_song_transport_ctrl.sv
// Scoreboard bench: every visible output change is popped against a queued expectation.
module tb_zbt_song_transport_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic        start;
    logic        done;
    logic        pause;
    logic        rec;
    logic [3:0]  choice;
    logic [18:0] a0;
    logic [18:0] a1;
  } obs_t;

  localparam logic [2:0] IDLE = 3'd0, PLAY = 3'd1, REC = 3'd2, PAUSED = 3'd3, DONE = 3'd4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic        a_ready = 0, a_start = 0, a_stop = 0, a_pause = 0, a_rec = 0;
  logic [3:0]  a_sel = 0;
  logic        a_start_song, a_rec_mode, a_pause_song, a_done;
  logic [3:0]  a_choice;
  logic [18:0] a_addr0, a_addr1;
  logic [2:0]  a_state;

  logic        b_ready = 0, b_start = 0, b_stop = 0, b_pause = 0, b_rec = 0;
  logic [3:0]  b_sel = 0;
  logic        b_start_song, b_rec_mode, b_pause_song, b_done;
  logic [3:0]  b_choice;
  logic [6:0]  b_addr0, b_addr1;
  logic [2:0]  b_state;

  int n_checks = 0;
  int n_errors = 0;

  obs_t  exp_a[$], exp_b[$];
  string nm_a[$], nm_b[$];
  obs_t  prev_a, prev_b;
  bit    have_a = 0, have_b = 0;

  always #5 clk = ~clk;

  zbt_song_transport_ctrl u_dut (
    .clk           (clk),
    .reset         (reset),
    .i_ready       (a_ready),
    .i_btn_start   (a_start),
    .i_btn_stop    (a_stop),
    .i_btn_pause   (a_pause),
    .i_record_sw   (a_rec),
    .i_song_sel    (a_sel),
    .o_start_song  (a_start_song),
    .o_record_mode (a_rec_mode),
    .o_song_choice (a_choice),
    .o_pause_song  (a_pause_song),
    .o_song_done   (a_done),
    .o_addr0       (a_addr0),
    .o_addr1       (a_addr1),
    .o_state       (a_state)
  );

  // Tiny slots (16 words) so a record can run to the end of its slot quickly.
  zbt_song_transport_ctrl #(
    .ADDR_W    (7),
    .SLOT_BITS (3)
  ) u_small (
    .clk           (clk),
    .reset         (reset),
    .i_ready       (b_ready),
    .i_btn_start   (b_start),
    .i_btn_stop    (b_stop),
    .i_btn_pause   (b_pause),
    .i_record_sw   (b_rec),
    .i_song_sel    (b_sel),
    .o_start_song  (b_start_song),
    .o_record_mode (b_rec_mode),
    .o_song_choice (b_choice),
    .o_pause_song  (b_pause_song),
    .o_song_done   (b_done),
    .o_addr0       (b_addr0),
    .o_addr1       (b_addr1),
    .o_state       (b_state)
  );

  function automatic obs_t mk(input logic [2:0] st, input logic start, input logic rec,
                              input logic [3:0] ch, input logic [18:0] a0,
                              input logic [18:0] a1);
    obs_t o;
    o.st     = st;
    o.start  = start;
    o.done   = (st == DONE) || (st == IDLE);
    o.pause  = (st == PAUSED) || (st == IDLE);
    o.rec    = rec;
    o.choice = ch;
    o.a0     = a0;
    o.a1     = a1;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d start=%0b done=%0b pause=%0b rec=%0b choice=%h a0=%h a1=%h",
                     o.st, o.start, o.done, o.pause, o.rec, o.choice, o.a0, o.a1);
  endfunction

  task automatic push(input int which, input string nm, input obs_t o);
    if (which == 0) begin
      exp_a.push_back(o);
      nm_a.push_back(nm);
    end else begin
      exp_b.push_back(o);
      nm_b.push_back(nm);
    end
  endtask

  task automatic observe(input int which, input obs_t cur);
    obs_t  e;
    string nm;
    bit    hit;
    bit    empty;
    hit = 0;
    if (which == 0) begin
      if (!have_a || (cur !== prev_a)) begin
        hit = 1; have_a = 1; prev_a = cur;
      end
      empty = (exp_a.size() == 0);
    end else begin
      if (!have_b || (cur !== prev_b)) begin
        hit = 1; have_b = 1; prev_b = cur;
      end
      empty = (exp_b.size() == 0);
    end
    if (hit) begin
      n_checks++;
      if (empty) begin
        n_errors++;
        $display("FAIL dut%0d_unexpected_change: got %s required no change", which, fmt(cur));
      end else begin
        if (which == 0) begin
          e = exp_a.pop_front(); nm = nm_a.pop_front();
        end else begin
          e = exp_b.pop_front(); nm = nm_b.pop_front();
        end
        if (cur !== e) begin
          n_errors++;
          $display("FAIL %s: got %s required %s", nm, fmt(cur), fmt(e));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      observe(0, {a_state, a_start_song, a_done, a_pause_song, a_rec_mode, a_choice,
                  a_addr0, a_addr1});
      observe(1, {b_state, b_start_song, b_done, b_pause_song, b_rec_mode, b_choice,
                  12'd0, b_addr0, 12'd0, b_addr1});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int which, input logic st, input logic sp, input logic pa,
                       input logic rec, input logic [3:0] sel);
    if (which == 0) begin
      a_start = st; a_stop = sp; a_pause = pa; a_rec = rec; a_sel = sel;
    end else begin
      b_start = st; b_stop = sp; b_pause = pa; b_rec = rec; b_sel = sel;
    end
    cyc();
    if (which == 0) begin
      a_start = 0; a_stop = 0; a_pause = 0;
    end else begin
      b_start = 0; b_stop = 0; b_pause = 0;
    end
    cyc();
  endtask

  task automatic readys(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      if (which == 0) a_ready = 1; else b_ready = 1;
      cyc();
      if (which == 0) a_ready = 0; else b_ready = 0;
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    push(0, "reset_a", mk(IDLE, 0, 0, 4'h0, 19'h0, 19'h0));
    push(1, "reset_b", mk(IDLE, 0, 0, 4'h0, 19'h0, 19'h0));
    repeat (3) cyc();
    reset = 0;
    cyc();

    // Record slot A (bank 1, slot 2): 30 samples = 10 words, then stop.
    push(0, "rec_a_start", mk(REC, 1, 1, 4'hA, 19'h0, 19'h20000));
    push(0, "rec_a_start_fall", mk(REC, 0, 1, 4'hA, 19'h0, 19'h20000));
    for (int k = 1; k <= 10; k++)
      push(0, $sformatf("rec_a_word%0d", k), mk(REC, 0, 1, 4'hA, 19'h0, 19'h20000 + 19'(k)));
    push(0, "rec_a_stop", mk(DONE, 0, 1, 4'hA, 19'h0, 19'h2000A));
    press(0, 1, 0, 0, 1, 4'hA);
    readys(0, 30);
    press(0, 0, 1, 0, 0, 4'h0);

    // Play slot A back: ends on the 30th sample at word 9.
    push(0, "play_a_start", mk(PLAY, 1, 0, 4'hA, 19'h0, 19'h20000));
    push(0, "play_a_start_fall", mk(PLAY, 0, 0, 4'hA, 19'h0, 19'h20000));
    for (int k = 1; k <= 9; k++)
      push(0, $sformatf("play_a_word%0d", k), mk(PLAY, 0, 0, 4'hA, 19'h0, 19'h20000 + 19'(k)));
    push(0, "play_a_done", mk(DONE, 0, 0, 4'hA, 19'h0, 19'h20009));
    press(0, 1, 0, 0, 0, 4'hA);
    readys(0, 30);
    readys(0, 3);

    // Never-recorded slot 3: straight to DONE with start_song still pulsed.
    push(0, "play_3_empty", mk(DONE, 1, 0, 4'h3, 19'h30000, 19'h0));
    push(0, "play_3_start_fall", mk(DONE, 0, 0, 4'h3, 19'h30000, 19'h0));
    press(0, 1, 0, 0, 0, 4'h3);

    // Pause mid-word: samples during pause must be neither counted nor lost.
    push(0, "pause_play_start", mk(PLAY, 1, 0, 4'hA, 19'h0, 19'h20000));
    push(0, "pause_play_start_fall", mk(PLAY, 0, 0, 4'hA, 19'h0, 19'h20000));
    push(0, "pause_word1", mk(PLAY, 0, 0, 4'hA, 19'h0, 19'h20001));
    push(0, "pause_enter", mk(PAUSED, 0, 0, 4'hA, 19'h0, 19'h20001));
    push(0, "pause_exit", mk(PLAY, 0, 0, 4'hA, 19'h0, 19'h20001));
    push(0, "pause_word2", mk(PLAY, 0, 0, 4'hA, 19'h0, 19'h20002));
    press(0, 1, 0, 0, 0, 4'hA);
    readys(0, 4);
    press(0, 0, 0, 1, 0, 4'h0);
    readys(0, 5);
    press(0, 0, 0, 1, 0, 4'h0);
    readys(0, 2);

    // Start and stop together while playing: stop wins, selection not latched.
    push(0, "start_stop_same", mk(DONE, 0, 0, 4'hA, 19'h0, 19'h20002));
    press(0, 1, 1, 0, 0, 4'h5);

    // Record slot 1 (bank 0), pause, then stop from PAUSED: length 2 words kept.
    push(0, "rec_1_start", mk(REC, 1, 1, 4'h1, 19'h10000, 19'h0));
    push(0, "rec_1_start_fall", mk(REC, 0, 1, 4'h1, 19'h10000, 19'h0));
    push(0, "rec_1_word1", mk(REC, 0, 1, 4'h1, 19'h10001, 19'h0));
    push(0, "rec_1_word2", mk(REC, 0, 1, 4'h1, 19'h10002, 19'h0));
    push(0, "rec_1_paused", mk(PAUSED, 0, 1, 4'h1, 19'h10002, 19'h0));
    push(0, "rec_1_stop", mk(DONE, 0, 1, 4'h1, 19'h10002, 19'h0));
    press(0, 1, 0, 0, 1, 4'h1);
    readys(0, 7);
    press(0, 0, 0, 1, 0, 4'h0);
    press(0, 0, 1, 0, 0, 4'h0);
    push(0, "play_1_start", mk(PLAY, 1, 0, 4'h1, 19'h10000, 19'h0));
    push(0, "play_1_start_fall", mk(PLAY, 0, 0, 4'h1, 19'h10000, 19'h0));
    push(0, "play_1_word1", mk(PLAY, 0, 0, 4'h1, 19'h10001, 19'h0));
    push(0, "play_1_done", mk(DONE, 0, 0, 4'h1, 19'h10001, 19'h0));
    press(0, 1, 0, 0, 0, 4'h1);
    readys(0, 6);

    // Small instance: record to the last word of the slot, then play that length back.
    push(1, "full_rec_start", mk(REC, 1, 1, 4'h0, 19'h0, 19'h0));
    push(1, "full_rec_start_fall", mk(REC, 0, 1, 4'h0, 19'h0, 19'h0));
    for (int k = 1; k <= 15; k++)
      push(1, $sformatf("full_rec_word%0d", k), mk(REC, 0, 1, 4'h0, 19'(k), 19'h0));
    push(1, "full_rec_done", mk(DONE, 0, 1, 4'h0, 19'd15, 19'h0));
    press(1, 1, 0, 0, 1, 4'h0);
    readys(1, 48);
    readys(1, 2);
    push(1, "full_play_start", mk(PLAY, 1, 0, 4'h0, 19'h0, 19'h0));
    push(1, "full_play_start_fall", mk(PLAY, 0, 0, 4'h0, 19'h0, 19'h0));
    for (int k = 1; k <= 14; k++)
      push(1, $sformatf("full_play_word%0d", k), mk(PLAY, 0, 0, 4'h0, 19'(k), 19'h0));
    push(1, "full_play_done", mk(DONE, 0, 0, 4'h0, 19'd14, 19'h0));
    press(1, 1, 0, 0, 0, 4'h0);
    readys(1, 45);

    repeat (5) cyc();
    n_checks++;
    if (exp_a.size() != 0) begin
      n_errors++;
      $display("FAIL pending_a: got %0d outstanding required 0 (next %s)", exp_a.size(),
               nm_a[0]);
    end
    n_checks++;
    if (exp_b.size() != 0) begin
      n_errors++;
      $display("FAIL pending_b: got %0d outstanding required 0 (next %s)", exp_b.size(),
               nm_b[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
